// File: rtl/multicycle_main_control_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_main_control_pkg : state, ALUOp, opcode and funct encodings
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package multicycle_main_control_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_ORIEX  = 4'd9,
    ST_ORIWB  = 4'd10,
    ST_BRANCH = 4'd11,
    ST_JUMP   = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_OPC   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;

  // States that hold a memory access open and are watched by the timeout timer
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_main_control_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer : counts stalled memory cycles and flags an access timeout
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [8:0] C_LIMIT = 9'(MEM_TIMEOUT);

  logic [7:0] r_count;

  // r_count holds the stalled cycles already seen, so the limit hits on the Nth stall
  assign timeout = (C_LIMIT != 9'd0) && active && !mem_ready &&
                   (({1'b0, r_count} + 9'd1) == C_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (!active || mem_ready || timeout) begin
      r_count <= 8'd0;
    end else if (r_count != 8'hFF) begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_main_control.sv
// -----------------------------------------------------------------------------
// multicycle_main_control : main sequencing FSM of the multi-cycle MIPS core
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       zext_imm,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_o
);

  state_t r_state;
  state_t w_next;
  logic   r_is_store;
  logic   w_mem_active;
  logic   w_timeout;

  assign w_mem_active = is_mem_state(r_state);
  assign state_o      = r_state;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (w_mem_active),
    .mem_ready (mem_ready),
    .timeout   (w_timeout)
  );

  // The IR is only trusted in DECODE, so remember lw/sw for the MEMADR branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_is_store <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_is_store <= (opcode == OP_SW);
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    alu_op        = ALUOP_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    pc_source     = PCSRC_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    zext_imm      = 1'b0;
    illegal_op    = 1'b0;
    bus_err       = 1'b0;

    case (r_state)
      ST_IDLE: w_next = ST_FETCH;

      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = ST_DECODE;
        end else if (w_timeout) begin
          bus_err = 1'b1;
          w_next  = ST_FETCH;
        end
      end

      ST_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_RTYPE: begin
            if (funct == FUNCT_ADDU || funct == FUNCT_SUBU) begin
              w_next = ST_EXEC;
            end else begin
              illegal_op = 1'b1;
              w_next     = ST_FETCH;
            end
          end
          OP_LW, OP_SW: w_next = ST_MEMADR;
          OP_BEQ:       w_next = ST_BRANCH;
          OP_ORI:       w_next = ST_ORIEX;
          OP_J:         w_next = ST_JUMP;
          default: begin
            illegal_op = 1'b1;
            w_next     = ST_FETCH;
          end
        endcase
      end

      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = r_is_store ? ST_MEMWR : ST_MEMRD;
      end

      ST_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) begin
          w_next = ST_MEMWB;
        end else if (w_timeout) begin
          bus_err = 1'b1;
          w_next  = ST_FETCH;
        end
      end

      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = ST_FETCH;
      end

      ST_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          w_next = ST_FETCH;
        end else if (w_timeout) begin
          bus_err = 1'b1;
          w_next  = ST_FETCH;
        end
      end

      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        w_next    = ST_ALUWB;
      end

      ST_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_next    = ST_FETCH;
      end

      ST_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        zext_imm  = 1'b1;
        alu_op    = ALUOP_OPC;
        w_next    = ST_ORIWB;
      end

      ST_ORIWB: begin
        reg_write = 1'b1;
        w_next    = ST_FETCH;
      end

      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_OPC;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        w_next        = ST_FETCH;
      end

      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        w_next    = ST_FETCH;
      end

      default: w_next = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_main_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_control : vector table, reset sequences and random instruction stream
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_main_control;
  import multicycle_main_control_pkg::*;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic [1:0] alu_op, alu_src_b, pc_source;
  logic       alu_src_a, pc_write, pc_write_cond, i_or_d, mem_req, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, zext_imm, illegal_op, bus_err;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  multicycle_main_control #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_req(mem_req),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .zext_imm(zext_imm), .illegal_op(illegal_op), .bus_err(bus_err),
    .state_o(state_o)
  );

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write, pc_write_cond, i_or_d, mem_req, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, zext_imm, illegal_op, bus_err;
  } ctrl_t;

  typedef struct {
    logic       ready;
    logic [5:0] op, fn;
    logic [3:0] st;
    ctrl_t      c;
  } cyc_t;

  typedef struct {
    string      name;
    logic [5:0] op, fn;
    int         fw, mw, cyc, regw, ill, berr;
  } vec_t;

  ctrl_t act;
  assign act = {alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond, i_or_d,
                mem_req, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, zext_imm,
                illegal_op, bus_err};

  cyc_t q[$];
  int   n_chk = 0, n_fail = 0, n_cyc = 0;
  int   obs_cyc, obs_regw, obs_ill, obs_berr;
  bit   obs_left, obs_done;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Expected control word of each phase, straight from the phase descriptions
  function automatic ctrl_t phase_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH:  begin c.mem_req = 1; c.alu_src_b = 2'b01; end
      ST_DECODE: c.alu_src_b = 2'b11;
      ST_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      ST_MEMRD:  begin c.mem_req = 1; c.i_or_d = 1; end
      ST_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      ST_MEMWR:  begin c.mem_req = 1; c.mem_write = 1; c.i_or_d = 1; end
      ST_EXEC:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      ST_ALUWB:  begin c.reg_write = 1; c.reg_dst = 1; end
      ST_ORIEX:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.zext_imm = 1; c.alu_op = 2'b01; end
      ST_ORIWB:  c.reg_write = 1;
      ST_BRANCH: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      ST_JUMP:   begin c.pc_write = 1; c.pc_source = 2'b10; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Opcode/funct are scrambled outside DECODE: only the decode cycle may look at them
  task automatic push(input state_t s, input logic rdy, input ctrl_t c,
                      input bit dec = 0, input logic [5:0] op = 0, input logic [5:0] fn = 0);
    cyc_t r;
    r.ready = rdy;
    r.op    = dec ? op : 6'($urandom);
    r.fn    = dec ? fn : 6'($urandom);
    r.st    = s;
    r.c     = c;
    q.push_back(r);
  endtask

  task automatic access(input state_t s, input int nwait, output bit ok);
    ctrl_t c;
    ok = 1;
    for (int k = 0; k < nwait; k++) begin
      c = phase_ctrl(s);
      if (k == T - 1) begin
        c.bus_err = 1;
        push(s, 1'b0, c);
        ok = 0;
        return;
      end
      push(s, 1'b0, c);
    end
    c = phase_ctrl(s);
    if (s == ST_FETCH) begin c.ir_write = 1; c.pc_write = 1; end
    push(s, 1'b1, c);
  endtask

  // Reference model: expand one instruction into its expected cycle-by-cycle trace
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    bit    ok;
    int    w;
    ctrl_t c;
    w = fw;
    do begin
      access(ST_FETCH, w, ok);
      if (!ok) w -= T;
    end while (!ok);
    c = phase_ctrl(ST_DECODE);
    if (op == 6'b000000 && (fn == 6'b100001 || fn == 6'b100011)) begin
      push(ST_DECODE, 1'($urandom), c, 1, op, fn);
      push(ST_EXEC, 1'($urandom), phase_ctrl(ST_EXEC));
      push(ST_ALUWB, 1'($urandom), phase_ctrl(ST_ALUWB));
    end else if (op == 6'b100011) begin
      push(ST_DECODE, 1'($urandom), c, 1, op, fn);
      push(ST_MEMADR, 1'($urandom), phase_ctrl(ST_MEMADR));
      access(ST_MEMRD, mw, ok);
      if (ok) push(ST_MEMWB, 1'($urandom), phase_ctrl(ST_MEMWB));
    end else if (op == 6'b101011) begin
      push(ST_DECODE, 1'($urandom), c, 1, op, fn);
      push(ST_MEMADR, 1'($urandom), phase_ctrl(ST_MEMADR));
      access(ST_MEMWR, mw, ok);
    end else if (op == 6'b000100) begin
      push(ST_DECODE, 1'($urandom), c, 1, op, fn);
      push(ST_BRANCH, 1'($urandom), phase_ctrl(ST_BRANCH));
    end else if (op == 6'b001101) begin
      push(ST_DECODE, 1'($urandom), c, 1, op, fn);
      push(ST_ORIEX, 1'($urandom), phase_ctrl(ST_ORIEX));
      push(ST_ORIWB, 1'($urandom), phase_ctrl(ST_ORIWB));
    end else if (op == 6'b000010) begin
      push(ST_DECODE, 1'($urandom), c, 1, op, fn);
      push(ST_JUMP, 1'($urandom), phase_ctrl(ST_JUMP));
    end else begin
      c.illegal_op = 1;
      push(ST_DECODE, 1'($urandom), c, 1, op, fn);
    end
  endtask

  task automatic obs_clear();
    obs_cyc = 0; obs_regw = 0; obs_ill = 0; obs_berr = 0; obs_left = 0; obs_done = 0;
  endtask

  task automatic replay(input int limit);
    cyc_t r;
    for (int i = 0; i < limit && q.size() > 0; i++) begin
      r = q.pop_front();
      @(negedge clk);
      opcode = r.op; funct = r.fn; mem_ready = r.ready;
      #1;
      n_cyc++;
      check($sformatf("cycle%0d {state,ctrl}", n_cyc), 32'({state_o, act}), 32'({r.st, r.c}));
      obs_regw += int'(reg_write);
      obs_ill  += int'(illegal_op);
      obs_berr += int'(bus_err);
      if (!obs_done) begin
        if (state_o == 4'(ST_FETCH) && obs_left) obs_done = 1;
        else begin
          obs_cyc++;
          if (state_o != 4'(ST_FETCH)) obs_left = 1;
        end
      end
    end
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{"addu",          6'b000000, 6'b100001, 0, 0, 4, 1, 0, 0};
    tbl[1]  = '{"subu",          6'b000000, 6'b100011, 0, 0, 4, 1, 0, 0};
    tbl[2]  = '{"lw_wait3",      6'b100011, 6'b010101, 0, 3, 8, 1, 0, 0};
    tbl[3]  = '{"lw",            6'b100011, 6'b000000, 0, 0, 5, 1, 0, 0};
    tbl[4]  = '{"sw",            6'b101011, 6'b111111, 0, 0, 4, 0, 0, 0};
    tbl[5]  = '{"sw_wait2",      6'b101011, 6'b000000, 0, 2, 6, 0, 0, 0};
    tbl[6]  = '{"beq",           6'b000100, 6'b100001, 0, 0, 3, 0, 0, 0};
    tbl[7]  = '{"j",             6'b000010, 6'b000000, 0, 0, 3, 0, 0, 0};
    tbl[8]  = '{"ori",           6'b001101, 6'b000000, 0, 0, 4, 1, 0, 0};
    tbl[9]  = '{"illegal_op",    6'b111111, 6'b100001, 0, 0, 2, 0, 1, 0};
    tbl[10] = '{"illegal_funct", 6'b000000, 6'b100000, 0, 0, 2, 0, 1, 0};
    tbl[11] = '{"fetch_ready_c4",6'b000000, 6'b100001, 3, 0, 7, 1, 0, 0};
    tbl[12] = '{"fetch_timeout", 6'b000000, 6'b100001, 4, 0, 8, 1, 0, 1};
    tbl[13] = '{"lw_timeout",    6'b100011, 6'b000000, 0, 4, 7, 0, 0, 1};

    rst_n = 1'b0; opcode = '0; funct = '0; mem_ready = 1'b0;
    #2;
    check("reset_state", 32'({state_o, act}), 32'({4'(ST_IDLE), 21'd0}));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle_after_release", 32'({state_o, act}), 32'({4'(ST_IDLE), 21'd0}));

    foreach (tbl[i]) begin
      obs_clear();
      build(tbl[i].op, tbl[i].fn, tbl[i].fw, tbl[i].mw);
      replay(q.size());
      check({tbl[i].name, " cycles"},   32'(obs_cyc),  32'(tbl[i].cyc));
      check({tbl[i].name, " reg_write"},32'(obs_regw), 32'(tbl[i].regw));
      check({tbl[i].name, " illegal"},  32'(obs_ill),  32'(tbl[i].ill));
      check({tbl[i].name, " bus_err"},  32'(obs_berr), 32'(tbl[i].berr));
    end

    // Reset in the middle of a stalled MEMRD must clear everything immediately
    obs_clear();
    build(6'b100011, 6'b000000, 0, 3);
    replay(5);
    q.delete();
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_memrd", 32'({state_o, act}), 32'({4'(ST_IDLE), 21'd0}));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle_after_mid_reset", 32'({state_o, act}), 32'({4'(ST_IDLE), 21'd0}));

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      int sel, fw, mw;
      sel = int'($urandom_range(0, 8));
      fn  = ($urandom_range(0, 3) == 0) ? 6'($urandom) :
            ($urandom_range(0, 1) == 0) ? 6'b100001 : 6'b100011;
      case (sel)
        0, 1:    op = 6'b000000;
        2:       op = 6'b100011;
        3:       op = 6'b101011;
        4:       op = 6'b000100;
        5:       op = 6'b001101;
        6:       op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      fw = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 2));
      mw = int'($urandom_range(0, 5));
      obs_clear();
      build(op, fn, fw, mw);
      replay(q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
